vga_scan_driver: RTL and testbench
==================================

Name: vga_scan_driver

Overview:
- VGA raster timing generator and pixel output stage for the room display path.
- Scans 640x480@60 Hz (25 MHz pixel clock) and drives CurrentX/CurrentY to the active room map module.
- Takes the map's registered 8-bit colour back, aligns it with delayed sync/blank and drives the DAC pins.
- Sole consumer of mapData; the room modules are the producers.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch clocks
- H_SYNC, 96, hsync pulse clocks
- H_BACK, 48, horizontal back porch clocks
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch lines
- V_SYNC, 2, vsync pulse lines
- V_BACK, 33, vertical back porch lines
- SYNC_ACTIVE, 0, level of hsync/vsync during the pulse (0 = negative sync)
- MAP_LATENCY, 1, clocks from CurrentX/Y to valid mapData; legal range 0..4

Ports:
- clk_vga  in  1  pixel clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- mapData  in  8  colour from room map, RRRGGGBB
- CurrentX  out  10  current scan column
- CurrentY  out  9  current scan row
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- red  out  3  DAC red
- green  out  3  DAC green
- blue  out  2  DAC blue
- frame_start  out  1  one-clock pulse at start of each frame

Behaviour:
- Counters:
  - h_cnt 10b runs 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800); wraps to 0.
  - v_cnt 10b increments only on h_cnt wrap; runs 0..V_TOTAL-1 (525); wraps to 0.
- CurrentX = h_cnt when h_cnt < H_VISIBLE, else 0. CurrentY = v_cnt[8:0] when v_cnt < V_VISIBLE, else 0. Both are combinational decode of the counter registers; no glitch-sensitive logic downstream.
- Raw timing, decoded each cycle:
  - active = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE)
  - hs_raw = SYNC_ACTIVE when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC, else ~SYNC_ACTIVE
  - vs_raw decoded the same way on v_cnt
- Alignment:
  - active, hs_raw and vs_raw pass through a shift register of depth MAP_LATENCY+1.
  - hsync and vsync are the last stage.
  - When the delayed active is 1 at a clock edge, {red,green,blue} <= mapData; otherwise they load 0.
  - Net effect: colour and sync appear at the pins MAP_LATENCY+1 clocks after the matching CurrentX/Y (2 clocks at default).
- frame_start:
  - Registered; high for exactly one clock when the counters step from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Not asserted for the first frame after reset release.
  - Not delayed by the alignment pipe.
- Reset (asynchronous assert, synchronous release):
  - h_cnt=0, v_cnt=0, so CurrentX=0 and CurrentY=0.
  - All delay stages: active=0, sync=~SYNC_ACTIVE.
  - hsync=vsync=~SYNC_ACTIVE, red/green/blue=0, frame_start=0.
  - Reset mid-line or mid-frame restarts the scan at (0,0) on the first edge after release; no partial-pulse artefacts beyond the abrupt truncation.
- Boundaries:
  - The last visible pixel (639,479) is driven to the pins; pixel 640 is forced black regardless of mapData.
  - vsync edges coincide with h_cnt=0 (line boundary) after the delay.
  - Counters never exceed H_TOTAL-1/V_TOTAL-1.
  - Width rule: parameters must satisfy H_TOTAL <= 1024, V_TOTAL <= 1024, V_VISIBLE <= 512. Violation is a configuration error, checked by an elaboration-time assertion.

Test Plan:
- Reset, then hold rst_n=0 for 5 clocks → hsync=vsync=1, RGB=0, CurrentX=0, CurrentY=0, frame_start=0 throughout.
- Free run after release, defaults → hsync low for exactly 96 clocks starting 658 clocks after the line's CurrentX=0 (656+2); line period 800 clocks; vsync low for 1600 clocks; frame period 420000 clocks; frame_start period 420000.
- mapData held at 8'b10110110 → during visible pixels red=3'b101, green=3'b101, blue=2'b10; during porch/sync RGB=0. The first coloured pixel appears 2 clocks after CurrentX=0,CurrentY=0.
- Model map returns mapData = CurrentX[7:0] registered (latency 1) → pins show 0,1,2,...,255,0,... in order with no skipped or duplicated pixel; the transition to black is at the 641st clock of the line window.
- Assert rst_n=0 at h_cnt=300, v_cnt=200 for 3 clocks → outputs reach reset values asynchronously; after release the scan restarts at (0,0) and the next frame_start occurs 420000 clocks later.
- Rebuild with MAP_LATENCY=0 and MAP_LATENCY=3 → the pin pipeline delay equals 1 and 4 clocks respectively; sync-to-colour alignment is unchanged.

Source files
------------

// File: rtl/vga_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_driver_if
//  Description : Scan-position / colour bus between the VGA scan driver and
//                the active room map. The driver publishes the pixel it is
//                scanning and the map returns that pixel's colour.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_scan_driver_if;
  logic [9:0] CurrentX;  // current scan column (0 outside the visible area)
  logic [8:0] CurrentY;  // current scan row (0 outside the visible area)
  logic [7:0] mapData;   // colour for (CurrentX, CurrentY), RRRGGGBB

  // Scan driver side: drives the position, consumes the colour
  modport master (output CurrentX, output CurrentY, input mapData);
  // Room map side: consumes the position, produces the colour
  modport slave  (input CurrentX, input CurrentY, output mapData);
endinterface
`default_nettype wire

// File: rtl/vga_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_driver
//  Description : 640x480@60 raster timing generator and pixel output stage.
//                Scans the frame, publishes the scan position to the room
//                map, and re-aligns the map's colour with delayed sync/blank
//                before driving the DAC pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_driver #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int MAP_LATENCY = 1
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  vga_scan_driver_if.master map_bus,
  output logic              hsync,
  output logic              vsync,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              frame_start
);

  localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // Sync/colour pipe depth: one stage per clock of map latency plus the
  // pin register itself
  localparam int c_depth   = MAP_LATENCY + 1;

  // Decode constants are one bit wider than the counters so that a sync
  // window ending exactly at 1024 still compares correctly
  localparam logic [10:0] c_h_vis    = 11'(H_VISIBLE);
  localparam logic [10:0] c_hs_start = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] c_hs_end   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] c_h_last   = 11'(c_h_total - 1);
  localparam logic [10:0] c_v_vis    = 11'(V_VISIBLE);
  localparam logic [10:0] c_vs_start = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] c_vs_end   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] c_v_last   = 11'(c_v_total - 1);

  // Counter widths and the 9-bit row output bound the legal timing set
  if (c_h_total > 1024 || c_v_total > 1024 || V_VISIBLE > 512 ||
      MAP_LATENCY < 0 || MAP_LATENCY > 4) begin : g_cfg_error
    $error("vga_scan_driver: illegal timing or latency configuration");
  end

  logic [9:0]        r_h_cnt;
  logic [9:0]        r_v_cnt;
  logic [10:0]       w_h_ext;
  logic [10:0]       w_v_ext;
  logic              w_h_last;
  logic              w_v_last;
  logic              w_h_vis;
  logic              w_v_vis;
  logic              w_active;
  logic              w_hs_raw;
  logic              w_vs_raw;
  logic              w_act_gate;
  logic [c_depth-1:0] r_hs_pipe;
  logic [c_depth-1:0] r_vs_pipe;

  assign w_h_ext  = {1'b0, r_h_cnt};
  assign w_v_ext  = {1'b0, r_v_cnt};
  assign w_h_last = (w_h_ext >= c_h_last);
  assign w_v_last = (w_v_ext >= c_v_last);
  assign w_h_vis  = (w_h_ext < c_h_vis);
  assign w_v_vis  = (w_v_ext < c_v_vis);
  assign w_active = w_h_vis & w_v_vis;
  assign w_hs_raw = (w_h_ext >= c_hs_start && w_h_ext < c_hs_end) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign w_vs_raw = (w_v_ext >= c_vs_start && w_v_ext < c_vs_end) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  // Scan position is a pure decode of the counters; blanking reads as 0
  assign map_bus.CurrentX = w_h_vis ? r_h_cnt : 10'd0;
  assign map_bus.CurrentY = w_v_vis ? r_v_cnt[8:0] : 9'd0;

  // Raster counters: column every clock, row on each column wrap
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
    end else if (w_h_last) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // Sync delay line; its last stage is the pin, so sync lands with colour
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_pipe <= {c_depth{~SYNC_ACTIVE}};
      r_vs_pipe <= {c_depth{~SYNC_ACTIVE}};
    end else begin
      r_hs_pipe[0] <= w_hs_raw;
      r_vs_pipe[0] <= w_vs_raw;
      for (int i = 1; i < c_depth; i++) begin
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
      end
    end
  end

  assign hsync = r_hs_pipe[c_depth-1];
  assign vsync = r_vs_pipe[c_depth-1];

  // The blank flag must arrive together with mapData, i.e. MAP_LATENCY
  // clocks late; the colour register then acts as the final blank stage
  if (MAP_LATENCY == 0) begin : g_gate_direct
    assign w_act_gate = w_active;
  end else begin : g_gate_pipe
    logic [MAP_LATENCY-1:0] r_act_pipe;

    // Blank delay line matching the map's read latency
    always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
        r_act_pipe <= '0;
      end else begin
        r_act_pipe[0] <= w_active;
        for (int i = 1; i < MAP_LATENCY; i++) begin
          r_act_pipe[i] <= r_act_pipe[i-1];
        end
      end
    end

    assign w_act_gate = r_act_pipe[MAP_LATENCY-1];
  end

  // Pin colour register: map colour inside the visible window, black outside
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      {red, green, blue} <= 8'd0;
    end else if (w_act_gate) begin
      {red, green, blue} <= map_bus.mapData;
    end else begin
      {red, green, blue} <= 8'd0;
    end
  end

  // Frame pulse on the (last,last) -> (0,0) step; undelayed by the pipe
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_h_last & w_v_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scan_driver
//  Description : Bench for vga_scan_driver. One instance runs the default
//                640x480 timing, a second runs a shrunken frame with positive
//                sync and a 3-clock map so whole frames fit in a short run.
//                Expected pins are derived from the elapsed clock count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_driver;

  localparam int B_HV = 24, B_HF = 3, B_HS = 5, B_HB = 4;
  localparam int B_VV = 10, B_VF = 2, B_VS = 3, B_VB = 2;
  localparam int B_FT = (B_HV + B_HF + B_HS + B_HB) * (B_VV + B_VF + B_VS + B_VB);

  typedef struct {
    int   hv, hf, hs, hb, vv, vf, vs, vb;
    logic sa;
    int   lat;
  } cfg_t;

  logic clk;
  logic rst_n;
  logic hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
  logic [2:0] r_a, g_a, r_b, g_b;
  logic [1:0] bl_a, bl_b;

  int          mode;
  logic [7:0]  const_col;
  logic [31:0] s1, s2, s3;
  int          k;
  int          n_checks = 0;
  int          n_pass   = 0;
  cfg_t        cfg_a, cfg_b;

  // Behavioural measurements
  logic prev_hs_a;
  int   hs_fall1, hs_fall2, hs_low_len, fs1, fs2, fs_a_count;

  vga_scan_driver_if bus_a ();
  vga_scan_driver_if bus_b ();

  vga_scan_driver dut_a (
    .clk_vga     (clk),
    .rst_n       (rst_n),
    .map_bus     (bus_a.master),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .red         (r_a),
    .green       (g_a),
    .blue        (bl_a),
    .frame_start (fs_a)
  );

  vga_scan_driver #(
    .H_VISIBLE (B_HV), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
    .V_VISIBLE (B_VV), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB),
    .SYNC_ACTIVE (1'b1), .MAP_LATENCY (3)
  ) dut_b (
    .clk_vga     (clk),
    .rst_n       (rst_n),
    .map_bus     (bus_b.master),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .red         (r_b),
    .green       (g_b),
    .blue        (bl_b),
    .frame_start (fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Room map content as a function of pixel position
  function automatic logic [7:0] map_fn(input logic [9:0] x, input logic [8:0] y);
    logic [31:0] t;
    case (mode)
      0:       t = {24'd0, const_col};
      1:       t = {22'd0, x};
      default: t = ({22'd0, x} * s1) ^ ({23'd0, y} * s2) ^ s3;
    endcase
    return t[7:0];
  endfunction

  // Stand-in room maps: 1-clock map for dut_a, 3-clock map for dut_b
  always @(posedge clk) bus_a.mapData <= map_fn(bus_a.CurrentX, bus_a.CurrentY);

  logic [7:0] b_map [0:2];
  always @(posedge clk) begin
    b_map[0] <= map_fn(bus_b.CurrentX, bus_b.CurrentY);
    b_map[1] <= b_map[0];
    b_map[2] <= b_map[1];
  end
  assign bus_b.mapData = b_map[2];

  // Expected {CurrentX, CurrentY, hsync, vsync, rgb, frame_start} after kk
  // clock edges since reset release (kk = 0 means in or just out of reset)
  task automatic model(input cfg_t c, input int kk, output logic [31:0] e);
    int ht, vt, ft, p, x, y, q, qx, qy;
    logic [9:0] cx;
    logic [8:0] cy;
    logic hsv, vsv, fsv;
    logic [7:0] rgb;
    ht  = c.hv + c.hf + c.hs + c.hb;
    vt  = c.vv + c.vf + c.vs + c.vb;
    ft  = ht * vt;
    p   = kk % ft;
    x   = p % ht;
    y   = p / ht;
    cx  = (x < c.hv) ? 10'(x) : 10'd0;
    cy  = (y < c.vv) ? 9'(y) : 9'd0;
    fsv = (kk > 0) && (p == 0);
    q   = kk - (c.lat + 1);
    hsv = ~c.sa;
    vsv = ~c.sa;
    rgb = 8'd0;
    if (q >= 0) begin
      qx = (q % ft) % ht;
      qy = (q % ft) / ht;
      if (qx >= c.hv + c.hf && qx < c.hv + c.hf + c.hs) hsv = c.sa;
      if (qy >= c.vv + c.vf && qy < c.vv + c.vf + c.vs) vsv = c.sa;
      if (qx < c.hv && qy < c.vv) rgb = map_fn(10'(qx), 9'(qy));
    end
    e = {2'b00, cx, cy, hsv, vsv, rgb, fsv};
  endtask

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [31:0] ea, eb;
    model(cfg_a, k, ea);
    model(cfg_b, k, eb);
    check_value($sformatf("a_pins k=%0d", k),
                {2'b00, bus_a.CurrentX, bus_a.CurrentY, hs_a, vs_a, r_a, g_a, bl_a, fs_a}, ea);
    check_value($sformatf("b_pins k=%0d", k),
                {2'b00, bus_b.CurrentX, bus_b.CurrentY, hs_b, vs_b, r_b, g_b, bl_b, fs_b}, eb);
  endtask

  task automatic clear_metrics();
    hs_fall1   = -1;
    hs_fall2   = -1;
    hs_low_len = 0;
    fs1        = -1;
    fs2        = -1;
    prev_hs_a  = hs_a;
  endtask

  // One clock: advance the elapsed count, sample at the falling edge
  task automatic step();
    @(posedge clk);
    if (rst_n) k++;
    @(negedge clk);
    check_all();
    if (rst_n) begin
      if (prev_hs_a && !hs_a) begin
        if (hs_fall1 < 0) hs_fall1 = k;
        else if (hs_fall2 < 0) hs_fall2 = k;
      end
      if (!hs_a && hs_fall1 >= 0 && hs_fall2 < 0) hs_low_len++;
      if (fs_b) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (fs_a) fs_a_count++;
    end
    prev_hs_a = hs_a;
  endtask

  task automatic reset_and_release(input int hold, input int new_mode);
    rst_n = 1'b0;
    k     = 0;
    mode  = new_mode;
    repeat (hold) step();
    clear_metrics();
    rst_n = 1'b1;
  endtask

  initial begin
    int gap;
    cfg_a = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33,
              sa: 1'b0, lat: 1};
    cfg_b = '{hv: B_HV, hf: B_HF, hs: B_HS, hb: B_HB, vv: B_VV, vf: B_VF,
              vs: B_VS, vb: B_VB, sa: 1'b1, lat: 3};
    rst_n      = 1'b0;
    k          = 0;
    mode       = 0;
    const_col  = 8'b1011_0110;
    s1         = $urandom;
    s2         = $urandom;
    s3         = $urandom;
    fs_a_count = 0;

    // Reset held for 5 clocks, then fixed colour
    reset_and_release(5, 0);
    repeat (2500) step();
    check_value("a_hs_first_fall", hs_fall1, 656 + 2);
    check_value("a_line_period", hs_fall2 - hs_fall1, 800);
    check_value("a_hs_low_len", hs_low_len, 96);
    check_value("b_fs_first", fs1, B_FT);
    check_value("b_fs_period", fs2 - fs1, B_FT);

    // Colour follows the column: 0,1,..,255,0,..
    reset_and_release(3, 1);
    repeat (2000) step();

    // Random map content, then an asynchronous reset mid-frame
    reset_and_release(3, 2);
    gap = $urandom_range(1500, 500);
    repeat (gap) step();
    #2 rst_n = 1'b0;
    #1 k = 0;
    check_all();
    s3 = $urandom;
    repeat (3) step();
    clear_metrics();
    rst_n = 1'b1;
    repeat (1300) step();
    check_value("b_fs_after_rst", fs1, B_FT);
    check_value("b_fs_period_rst", fs2 - fs1, B_FT);
    check_value("a_no_frame_start", fs_a_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
